ball_engine: RTL

- Parametrised ball motion engine for the Pong datapath.
- Driven by the game FSM state (START/SERVE/PLAY/DONE) and the paddle collision flags.
- Generalises screen geometry, ball size, tick rate and step size, and adds:
  - internal wall bounce with clamping
  - hit-count speed-up
  - pause
  - one-cycle score pulses

---
 rtl/ball_if.sv | 34 +++
 rtl/ball_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_if.sv
// Ball engine bus: game-side controls in, ball position and score events out.
// Latency: none (wires only).
// Backpressure: none; the engine samples its inputs on every clock.
interface ball_if #(
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int SPD_W = 3
);
  logic [1:0]       state;
  logic             serve;
  logic             pause;
  logic             hitL;
  logic             hitR;
  logic [X_W-1:0]   ballX;
  logic [Y_W-1:0]   ballY;
  logic             dirX;
  logic             dirY;
  logic [SPD_W-1:0] speed;
  logic [1:0]       ballStatus;
  logic             score1;
  logic             score2;

  // Game FSM side: drives controls, observes the ball
  modport master (
    output state, serve, pause, hitL, hitR,
    input  ballX, ballY, dirX, dirY, speed, ballStatus, score1, score2
  );

  // Ball engine side
  modport slave (
    input  state, serve, pause, hitL, hitR,
    output ballX, ballY, dirX, dirY, speed, ballStatus, score1, score2
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball motion: serve, tick-paced stepping, wall bounce, paddle speed-up, scoring.
// Latency: all outputs registered, one cycle from the sampled inputs.
// Backpressure: none; pause freezes motion and the tick counter while in PLAY.
module ball_engine #(
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int TICK_DIV     = 524288,
  parameter int MAX_SPEED    = 4,
  parameter int SPEEDUP_HITS = 4
) (
  input  logic  clk,
  input  logic  rst,
  ball_if.slave bus
);

  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int HIT_W = $clog2(SPEEDUP_HITS + 1);

  localparam logic [X_W-1:0]   OX       = X_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0]   OY       = Y_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [X_W:0]     XMAX     = (X_W + 1)'(SCREEN_W - BALL_SIZE);
  localparam logic [Y_W:0]     YMAX     = (Y_W + 1)'(SCREEN_H - BALL_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(SPEEDUP_HITS - 1);
  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED);
  localparam logic [SPD_W-1:0] SPD_ONE  = SPD_W'(1);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } game_e;

  localparam logic [1:0] BS_PLAYING = 2'b00;
  localparam logic [1:0] BS_P1WIN   = 2'b01;
  localparam logic [1:0] BS_P2WIN   = 2'b10;

  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             dirx_q, dirx_d;
  logic             diry_q, diry_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic [1:0]       status_q, status_d;
  logic             score1_q, score1_d;
  logic             score2_q, score2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic             hit_prev_q, hit_prev_d;

  logic             hit_now;
  logic             hit_rise;
  logic [X_W-1:0]   spd_x;
  logic [Y_W-1:0]   spd_y;
  logic [X_W:0]     x_sum;
  logic [Y_W:0]     y_sum;

  // Step arithmetic carries one extra bit so the far-wall test never wraps
  assign hit_now  = bus.hitL | bus.hitR;
  assign hit_rise = hit_now & ~hit_prev_q;
  assign spd_x    = X_W'(spd_q);
  assign spd_y    = Y_W'(spd_q);
  assign x_sum    = {1'b0, x_q} + {1'b0, spd_x};
  assign y_sum    = {1'b0, y_q} + {1'b0, spd_y};

  // Next-state: serve setup, paddle handling, tick-paced motion with bounce and scoring
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dirx_d     = dirx_q;
    diry_d     = diry_q;
    spd_d      = spd_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    hits_d     = hits_q;
    hit_prev_d = hit_prev_q;
    score1_d   = 1'b0;
    score2_d   = 1'b0;

    case (game_e'(bus.state))
      ST_SERVE: begin
        x_d        = OX;
        y_d        = OY;
        spd_d      = SPD_ONE;
        status_d   = BS_PLAYING;
        cnt_d      = '0;
        hits_d     = '0;
        hit_prev_d = 1'b0;
        dirx_d     = bus.serve;
        // Free-running toggle: the cycle PLAY starts on picks the vertical direction
        diry_d     = ~diry_q;
      end

      ST_PLAY: begin
        // Edge register follows the paddles even while paused or after a point
        hit_prev_d = hit_now;
        if (status_q == BS_PLAYING && !bus.pause) begin
          if (hit_rise) begin
            if (bus.hitL && bus.hitR) dirx_d = ~dirx_q;
            else if (bus.hitR)        dirx_d = 1'b1;
            else                      dirx_d = 1'b0;
            if (hits_q == HIT_LAST) begin
              hits_d = '0;
              if (spd_q != SPD_MAX) spd_d = spd_q + SPD_ONE;
            end else begin
              hits_d = hits_q + HIT_W'(1);
            end
          end

          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            // Motion uses the pre-update direction; wall hits override paddle dirY
            if (diry_q) begin
              if (y_q < spd_y) begin
                y_d    = '0;
                diry_d = 1'b0;
              end else begin
                y_d = y_q - spd_y;
              end
            end else begin
              if (y_sum > YMAX) begin
                y_d    = YMAX[Y_W-1:0];
                diry_d = 1'b1;
              end else begin
                y_d = y_sum[Y_W-1:0];
              end
            end

            if (dirx_q) begin
              if (x_q < spd_x) begin
                x_d      = '0;
                status_d = BS_P2WIN;
                score2_d = 1'b1;
              end else begin
                x_d = x_q - spd_x;
              end
            end else begin
              if (x_sum > XMAX) begin
                x_d      = XMAX[X_W-1:0];
                status_d = BS_P1WIN;
                score1_d = 1'b1;
              end else begin
                x_d = x_sum[X_W-1:0];
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        // START and DONE hold the ball parked at centre
        x_d        = OX;
        y_d        = OY;
        dirx_d     = 1'b0;
        diry_d     = 1'b0;
        spd_d      = SPD_ONE;
        status_d   = BS_PLAYING;
        cnt_d      = '0;
        hits_d     = '0;
        hit_prev_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= OX;
      y_q        <= OY;
      dirx_q     <= 1'b0;
      diry_q     <= 1'b0;
      spd_q      <= SPD_ONE;
      status_q   <= BS_PLAYING;
      score1_q   <= 1'b0;
      score2_q   <= 1'b0;
      cnt_q      <= '0;
      hits_q     <= '0;
      hit_prev_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dirx_q     <= dirx_d;
      diry_q     <= diry_d;
      spd_q      <= spd_d;
      status_q   <= status_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      cnt_q      <= cnt_d;
      hits_q     <= hits_d;
      hit_prev_q <= hit_prev_d;
    end
  end

  assign bus.ballX      = x_q;
  assign bus.ballY      = y_q;
  assign bus.dirX       = dirx_q;
  assign bus.dirY       = diry_q;
  assign bus.speed      = spd_q;
  assign bus.ballStatus = status_q;
  assign bus.score1     = score1_q;
  assign bus.score2     = score2_q;

endmodule
